uart_rx_frame: RTL and testbench
================================

// Module: uart_rx_frame
// PURPOSE
//   Parametrised UART receiver. Successor to the fixed 8N1 receiver.
//   Adds configurable data/stop bits, 3-sample majority voting, false-start rejection,
//   framing/break/overrun detection and a valid/ready output holding register.
//   Sits between the pad-level rx line and byte-stream consumers (FIFO, command parser).
// PARAMETERS
//   CLK_HZ      25_000_000  system clock frequency, Hz
//   BAUD        9600        line rate; DIV = CLK_HZ/BAUD (integer, >= 8), HALF = DIV/2
//   DATA_BITS   8           data bits per frame, 5..9, LSB first
//   STOP_BITS   1           stop bits checked, 1 or 2
//   SYNC_STAGES 2           rx synchroniser depth, >= 2
//   PARITY_ODD  0           0 = even, 1 = odd; used only with UART_RX_PARITY_EN
// PORTS
//   clk       in   1          system clock, all logic on rising edge
//   rst       in   1          synchronous, active-high reset
//   rx        in   1          asynchronous serial line, idle high
//   m_data    out  DATA_BITS  received data, held while m_valid
//   m_ferr    out  1          framing error for m_data (a stop bit sampled low)
//   m_perr    out  1          parity error for m_data (0 when parity compiled out)
//   m_brk     out  1          break: all data bits 0 and first stop bit 0
//   m_valid   out  1          holding register occupied
//   m_ready   in   1          consumer accepts; transfer when m_valid && m_ready
//   overrun   out  1          1-cycle pulse: frame completed while holding register full
//   busy      out  1          1 while FSM not in IDLE
// BEHAVIOUR
//   - Reset: FSM=IDLE, synchroniser all 1s, counters 0; m_data=0, m_ferr=m_perr=m_brk=0,
//     m_valid=0, overrun=0, busy=0. rst mid-frame aborts; the partial frame is discarded.
//   - rxs = synchroniser output; start detect = rxs previous 1, current 0, only in IDLE.
//   - cnt_bps counts 0..DIV-1 per bit, cleared on start detect and at each DIV-1 wrap.
//   - Bit value = majority of rxs at cnt_bps = HALF-1, HALF, HALF+1; decided at HALF+1.
//   - FSM: IDLE -> START on start detect.
//     START: decided value 1 -> IDLE (false start, nothing output); 0 -> DATA at wrap.
//     DATA: DATA_BITS bits, LSB first, into shift reg; after last -> PARITY (if compiled) else STOP.
//     PARITY: sample parity bit -> STOP at wrap.
//     STOP: STOP_BITS bits; any sampled 0 sets ferr. Decision of LAST stop bit = frame
//       complete; FSM -> IDLE same cycle (re-arms at mid stop bit, no wrap wait).
//   - Completion cycle C: at C+1, if holding empty or (m_valid && m_ready at C):
//     load m_data/m_ferr/m_perr/m_brk, m_valid=1. Else drop new frame, overrun=1 at C+1,
//     holding register unchanged.
//   - Frames with ferr/perr are still delivered, flags attached; consumer decides.
//   - m_valid clears the cycle after m_valid && m_ready unless a load occurs the same cycle.
//   - Latency: m_valid rises one clk after last-stop decision (HALF+1 into the stop bit).
//   - busy independent of m_valid.
// CONFIGURATION
//   UART_RX_PARITY_EN defined: frame has one parity bit after data. Expected parity =
//     XOR(data) ^ PARITY_ODD; mismatch -> m_perr=1.
//   UART_RX_PARITY_EN undefined: no PARITY state, no parity bit, m_perr tied 0,
//     PARITY_ODD ignored.
// TESTING  (CLK_HZ=1_000_000, BAUD=100_000 -> DIV=10, HALF=5; DATA_BITS=8, STOP_BITS=1)
//   1. Send 0xA5 8N1, m_ready=1 -> m_valid pulse, m_data=0xA5, m_ferr=0, m_perr=0,
//      m_valid rises 1 clk after cnt_bps=6 of stop bit.
//   2. 3-cycle low glitch on idle rx (cycles 2-4 after edge) -> START rejects,
//      busy drops, no m_valid.
//   3. Send 0x3C with stop bit held 0 -> m_data=0x3C, m_ferr=1.
//      All-zero data and stop 0 -> m_data=0x00, m_ferr=1, m_brk=1.
//   4. m_ready=0, send 0x11 then 0x22 back-to-back -> m_data stays 0x11,
//      overrun pulses 1 clk. Then m_ready=1 -> 0x11 accepted, m_valid falls.
//   5. UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity 1 -> m_perr=0;
//      with parity 0 -> m_perr=1. Without macro: m_perr always 0.
//   6. rst=1 for one cycle mid DATA of 0x55, then clean 0x99 -> only 0x99 delivered.
//      Also STOP_BITS=2 with second stop 0 -> m_ferr=1.

Source files
------------

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: sync + 3-sample majority, false-start rejection, framing/break/
// overrun flags, valid/ready holding register. Optional parity bit via UART_RX_PARITY_EN.
module uart_rx_frame #(
  parameter int unsigned CLK_HZ      = 25_000_000,
  parameter int unsigned BAUD        = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PARITY_ODD  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_ferr,
  output logic                 m_perr,
  output logic                 m_brk,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned DIV  = CLK_HZ / BAUD;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CntW = $clog2(DIV);
  localparam int unsigned IdxW = 4;

  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);
  localparam logic [CntW-1:0] CntS0   = CntW'(HALF - 1);
  localparam logic [CntW-1:0] CntS1   = CntW'(HALF);
  localparam logic [CntW-1:0] CntDec  = CntW'(HALF + 1);
  localparam logic [IdxW-1:0] DataLast = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0] StopLast = IdxW'(STOP_BITS - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StStop   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] StParity = 3'd4;
  localparam logic       ParOdd   = (PARITY_ODD != 0);
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs, rxs_prev_q;
  logic [2:0]             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [1:0]             smp_q, smp_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   ferr_q, ferr_d, brk_q, brk_d, perr_q, perr_d;
  logic                   wrap, dec, bit_val, done;

  logic [DATA_BITS-1:0]   m_data_q;
  logic                   m_ferr_q, m_perr_q, m_brk_q, m_valid_q, overrun_q;

  assign rxs     = sync_q[SYNC_STAGES-1];
  assign wrap    = (cnt_q == CntLast);
  assign dec     = (state_q != StIdle) && (cnt_q == CntDec);
  assign bit_val = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);

  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == StIdle || wrap) ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    smp_d   = smp_q;
    shreg_d = shreg_q;
    ferr_d  = ferr_q;
    brk_d   = brk_q;
    perr_d  = perr_q;
    done    = 1'b0;
    if (cnt_q == CntS0) smp_d[0] = rxs;
    if (cnt_q == CntS1) smp_d[1] = rxs;
    case (state_q)
      StIdle: begin
        if (rxs_prev_q && !rxs) begin
          state_d = StStart;
          cnt_d   = '0;
          idx_d   = '0;
          ferr_d  = 1'b0;
          brk_d   = 1'b0;
          perr_d  = 1'b0;
        end
      end
      StStart: begin
        if (dec && bit_val) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (wrap) begin
          state_d = StData;
        end
      end
      StData: begin
        if (dec) shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
        if (wrap) begin
          if (idx_q == DataLast) begin
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (dec) perr_d = bit_val ^ (^shreg_q) ^ ParOdd;
        if (wrap) state_d = StStop;
      end
`endif
      StStop: begin
        if (dec) begin
          if (!bit_val) ferr_d = 1'b1;
          if (idx_q == '0) brk_d = (shreg_q == '0) && !bit_val;
          // Completion re-arms at mid stop bit so back-to-back frames are not missed.
          if (idx_q == StopLast) begin
            done    = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
          end
        end else if (wrap) begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      smp_q      <= '0;
      shreg_q    <= '0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
      rxs_prev_q <= rxs;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      smp_q      <= smp_d;
      shreg_q    <= shreg_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      perr_q     <= perr_d;
    end
  end

  // Holding register: a completed frame is dropped (overrun) only if the slot stays occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data_q  <= '0;
      m_ferr_q  <= 1'b0;
      m_perr_q  <= 1'b0;
      m_brk_q   <= 1'b0;
      m_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (done && (!m_valid_q || m_ready)) begin
        m_data_q  <= shreg_q;
        m_ferr_q  <= ferr_d;
        m_perr_q  <= perr_d;
        m_brk_q   <= brk_d;
        m_valid_q <= 1'b1;
      end else begin
        if (done) overrun_q <= 1'b1;
        if (m_valid_q && m_ready) m_valid_q <= 1'b0;
      end
    end
  end

  assign m_data  = m_data_q;
  assign m_ferr  = m_ferr_q;
  assign m_brk   = m_brk_q;
  assign m_valid = m_valid_q;
  assign overrun = overrun_q;
  assign busy    = (state_q != StIdle);

`ifdef UART_RX_PARITY_EN
  assign m_perr = m_perr_q;
`else
  logic unused_parity;
  assign unused_parity = m_perr_q ^ (PARITY_ODD != 0);
  assign m_perr        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame at DIV=10: one 1-stop DUT and one 2-stop DUT.
module tb_uart_rx_frame;
  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int          DIV    = 10;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    logic       brk;
  } frame_t;

  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, rx2 = 1'b1;
  logic       m_ready = 1'b1, m_ready2 = 1'b1;
  logic [7:0] m_data, m_data2;
  logic       m_ferr, m_perr, m_brk, m_valid, overrun, busy;
  logic       m_ferr2, m_perr2, m_brk2, m_valid2, overrun2, busy2;

  frame_t q[$], q2[$], e, e2;
  int     checks = 0, errors = 0, cyc = 0, ovr_cycles = 0, ovr2_cycles = 0;
  int     start_cyc = 0, rise_cyc = -1;
  logic   valid_prev = 1'b0, busy_seen = 1'b0;

  uart_rx_frame #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .STOP_BITS(1),
                  .SYNC_STAGES(2), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .rx(rx), .m_data(m_data), .m_ferr(m_ferr), .m_perr(m_perr),
    .m_brk(m_brk), .m_valid(m_valid), .m_ready(m_ready), .overrun(overrun), .busy(busy));

  uart_rx_frame #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .STOP_BITS(2),
                  .SYNC_STAGES(2), .PARITY_ODD(0)) dut2 (
    .clk(clk), .rst(rst), .rx(rx2), .m_data(m_data2), .m_ferr(m_ferr2), .m_perr(m_perr2),
    .m_brk(m_brk2), .m_valid(m_valid2), .m_ready(m_ready2), .overrun(overrun2),
    .busy(busy2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic frame_t mk(input logic [7:0] d, input logic f, input logic p,
                                input logic b);
    frame_t r;
    r.data = d;
    r.ferr = f;
    r.perr = p;
    r.brk  = b;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && !valid_prev) rise_cyc = cyc;
      if (overrun) ovr_cycles++;
      if (busy) busy_seen = 1'b1;
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got data %0d expected no frame", m_data);
        end else begin
          e = q.pop_front();
          chk("data", m_data, e.data);
          chk("ferr", m_ferr, e.ferr);
          chk("perr", m_perr, e.perr);
          chk("brk", m_brk, e.brk);
        end
      end
    end
    valid_prev = m_valid;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (overrun2) ovr2_cycles++;
      if (m_valid2 && m_ready2) begin
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame2: got data %0d expected no frame", m_data2);
        end else begin
          e2 = q2.pop_front();
          chk("data2", m_data2, e2.data);
          chk("ferr2", m_ferr2, e2.ferr);
          chk("perr2", m_perr2, e2.perr);
          chk("brk2", m_brk2, e2.brk);
        end
      end
    end
  end

  task automatic bit_out(input int ln, input logic v);
    if (ln == 0) rx = v;
    else rx2 = v;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  // pflip inverts the parity bit (ignored when parity is compiled out).
  task automatic send(input int ln, input logic [7:0] d, input logic s0, input logic s1,
                      input int nstop, input logic pflip);
    bit_out(ln, 1'b0);
    for (int i = 0; i < 8; i++) bit_out(ln, d[i]);
    if (PAR != 0) bit_out(ln, (^d) ^ pflip);
    bit_out(ln, s0);
    if (nstop == 2) bit_out(ln, s1);
    if (ln == 0) rx = 1'b1;
    else rx2 = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle(3);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_ferr", m_ferr, 0);
    chk("rst_perr", m_perr, 0);
    chk("rst_brk", m_brk, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    idle(5);

    // Clean frame and latency from start edge to m_valid.
    q.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b0));
    start_cyc = cyc;
    send(0, 8'hA5, 1'b1, 1'b1, 1, 1'b0);
    idle(10);
    chk("latency", rise_cyc - start_cyc, 100 + 10 * PAR);

    // Short low glitch must be rejected as a false start.
    busy_seen = 1'b0;
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(30);
    chk("glitch_busy_seen", busy_seen, 1);
    chk("glitch_busy_drop", busy, 0);

    // Framing error, then break.
    q.push_back(mk(8'h3C, 1'b1, 1'b0, 1'b0));
    send(0, 8'h3C, 1'b0, 1'b1, 1, 1'b0);
    idle(20);
    q.push_back(mk(8'h00, 1'b1, 1'b0, 1'b1));
    send(0, 8'h00, 1'b0, 1'b1, 1, 1'b0);
    idle(20);

    // Overrun: second frame dropped while holding register is full.
    m_ready = 1'b0;
    ovr_cycles = 0;
    q.push_back(mk(8'h11, 1'b0, 1'b0, 1'b0));
    send(0, 8'h11, 1'b1, 1'b1, 1, 1'b0);
    send(0, 8'h22, 1'b1, 1'b1, 1, 1'b0);
    idle(5);
    chk("hold_valid", m_valid, 1);
    chk("hold_data", m_data, 8'h11);
    chk("overrun_pulses", ovr_cycles, 1);
    m_ready = 1'b1;
    idle(2);
    chk("valid_falls", m_valid, 0);
    idle(10);

    // Parity: correct then flipped (perr stays 0 without parity).
    q.push_back(mk(8'h07, 1'b0, 1'b0, 1'b0));
    send(0, 8'h07, 1'b1, 1'b1, 1, 1'b0);
    idle(20);
    q.push_back(mk(8'h07, 1'b0, (PAR != 0), 1'b0));
    send(0, 8'h07, 1'b1, 1'b1, 1, 1'b1);
    idle(20);

    // Reset mid-frame discards the partial 0x55.
    bit_out(0, 1'b0);
    bit_out(0, 1'b1);
    bit_out(0, 1'b0);
    bit_out(0, 1'b1);
    rst = 1'b1;
    rx  = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", m_valid, 0);
    chk("midrst_data", m_data, 0);
    idle(20);
    q.push_back(mk(8'h99, 1'b0, 1'b0, 1'b0));
    send(0, 8'h99, 1'b1, 1'b1, 1, 1'b0);
    idle(20);

    // Two stop bits: bad second stop, then clean frame.
    q2.push_back(mk(8'h5A, 1'b1, 1'b0, 1'b0));
    send(1, 8'h5A, 1'b1, 1'b0, 2, 1'b0);
    idle(20);
    q2.push_back(mk(8'h5A, 1'b0, 1'b0, 1'b0));
    send(1, 8'h5A, 1'b1, 1'b1, 2, 1'b0);
    idle(30);

    chk("drain", q.size(), 0);
    chk("drain2", q2.size(), 0);
    chk("overrun2_none", ovr2_cycles, 0);
    chk("busy2_idle", busy2, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
